// File: rtl/axis_frame_arbiter.sv
// rtl/axis_frame_arbiter.sv - frame-granular round-robin AXI4-Stream arbiter with registered output
//
// Merges S_COUNT AXI4-Stream sources onto one master. A grant is held from the
// first beat of a frame through its tlast beat, so frames never interleave.
// A single registered output stage isolates the arbiter from the consumer.
//
// Ports:
//   clk            clock, rising edge
//   rst            asynchronous active-low reset
//   s_axis_*       S_COUNT packed slave streams (port i at [i*W +: W])
//   m_axis_*       merged master stream (m_axis_tready is the only input)
//   grant_valid    high while a frame is granted
//   grant_index    granted port, valid while grant_valid
//   m_axis_tid     source port of each output beat (only with AXIS_ARB_TID_EN)
//
// Build option: define AXIS_ARB_TID_EN to add the m_axis_tid source tag.

module axis_frame_arbiter #(
    parameter int S_COUNT     = 4,
    parameter int DATA_WIDTH  = 8,
    parameter int KEEP_ENABLE = (DATA_WIDTH > 8),
    parameter int KEEP_WIDTH  = (DATA_WIDTH / 8),
    parameter int USER_WIDTH  = 1,
    localparam int CL_S_COUNT = $clog2(S_COUNT)
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [S_COUNT*DATA_WIDTH-1:0] s_axis_tdata,
    input  logic [S_COUNT*KEEP_WIDTH-1:0] s_axis_tkeep,
    input  logic [S_COUNT-1:0]            s_axis_tvalid,
    output logic [S_COUNT-1:0]            s_axis_tready,
    input  logic [S_COUNT-1:0]            s_axis_tlast,
    input  logic [S_COUNT*USER_WIDTH-1:0] s_axis_tuser,
    output logic [DATA_WIDTH-1:0]         m_axis_tdata,
    output logic [KEEP_WIDTH-1:0]         m_axis_tkeep,
    output logic                          m_axis_tvalid,
    input  logic                          m_axis_tready,
    output logic                          m_axis_tlast,
    output logic [USER_WIDTH-1:0]         m_axis_tuser,
`ifdef AXIS_ARB_TID_EN
    output logic [CL_S_COUNT-1:0]         m_axis_tid,
`endif
    output logic                          grant_valid,
    output logic [CL_S_COUNT-1:0]         grant_index
);

    typedef enum logic [0:0] {
        ST_IDLE   = 1'b0,
        ST_ACTIVE = 1'b1
    } state_t;

    state_t                  state;
    state_t                  state_next;
    logic [CL_S_COUNT-1:0]   rr_ptr;
    logic [CL_S_COUNT-1:0]   rr_ptr_next;
    logic [CL_S_COUNT-1:0]   grant_index_next;

    logic [CL_S_COUNT-1:0]   sel_hi;
    logic [CL_S_COUNT-1:0]   sel_lo;
    logic [CL_S_COUNT-1:0]   sel_index;
    logic                    hi_found;
    logic                    any_req;

    logic                    out_ready;
    logic                    beat_xfer;
    logic                    gnt_tvalid;
    logic                    gnt_tlast;
    logic [DATA_WIDTH-1:0]   gnt_tdata;
    logic [KEEP_WIDTH-1:0]   gnt_tkeep;
    logic [USER_WIDTH-1:0]   gnt_tuser;

    // Cyclic search from rr_ptr done as two linear priority scans: the lowest
    // requester at or above rr_ptr wins; otherwise the lowest requester overall
    // (the wrap-around case). Indices never reach S_COUNT.
    always_comb begin
        sel_hi   = '0;
        sel_lo   = '0;
        hi_found = 1'b0;
        for (int i = S_COUNT - 1; i >= 0; i--) begin
            if (s_axis_tvalid[i]) begin
                sel_lo = CL_S_COUNT'(i);
                if (CL_S_COUNT'(i) >= rr_ptr) begin
                    sel_hi   = CL_S_COUNT'(i);
                    hi_found = 1'b1;
                end
            end
        end
        sel_index = hi_found ? sel_hi : sel_lo;
    end

    assign any_req = |s_axis_tvalid;

    assign gnt_tvalid = s_axis_tvalid[grant_index];
    assign gnt_tlast  = s_axis_tlast[grant_index];
    assign gnt_tdata  = s_axis_tdata[grant_index*DATA_WIDTH +: DATA_WIDTH];
    assign gnt_tkeep  = s_axis_tkeep[grant_index*KEEP_WIDTH +: KEEP_WIDTH];
    assign gnt_tuser  = s_axis_tuser[grant_index*USER_WIDTH +: USER_WIDTH];

    // The output register can take a beat when empty or draining this cycle.
    assign out_ready = !m_axis_tvalid || m_axis_tready;
    assign beat_xfer = (state == ST_ACTIVE) && gnt_tvalid && out_ready;

    assign grant_valid = (state == ST_ACTIVE);

    always_comb begin
        s_axis_tready = '0;
        if (state == ST_ACTIVE) begin
            s_axis_tready[grant_index] = out_ready;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= ST_IDLE;
            rr_ptr      <= '0;
            grant_index <= '0;
        end else begin
            state       <= state_next;
            rr_ptr      <= rr_ptr_next;
            grant_index <= grant_index_next;
        end
    end

    always_comb begin
        state_next       = state;
        rr_ptr_next      = rr_ptr;
        grant_index_next = grant_index;
        case (state)
            ST_IDLE: begin
                if (any_req) begin
                    grant_index_next = sel_index;
                    state_next       = ST_ACTIVE;
                end
            end
            ST_ACTIVE: begin
                // Only an accepted tlast beat releases the grant; a source
                // dropping tvalid mid-frame simply stalls the arbiter.
                if (beat_xfer && gnt_tlast) begin
                    rr_ptr_next = (grant_index == CL_S_COUNT'(S_COUNT - 1))
                                  ? '0 : grant_index + CL_S_COUNT'(1);
                    state_next  = ST_IDLE;
                end
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            m_axis_tvalid <= 1'b0;
            m_axis_tdata  <= '0;
            m_axis_tkeep  <= '0;
            m_axis_tlast  <= 1'b0;
            m_axis_tuser  <= '0;
        end else if (beat_xfer) begin
            m_axis_tvalid <= 1'b1;
            m_axis_tdata  <= gnt_tdata;
            m_axis_tkeep  <= (KEEP_ENABLE != 0) ? gnt_tkeep : '1;
            m_axis_tlast  <= gnt_tlast;
            m_axis_tuser  <= gnt_tuser;
        end else if (m_axis_tready) begin
            m_axis_tvalid <= 1'b0;
        end
    end

`ifdef AXIS_ARB_TID_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            m_axis_tid <= '0;
        end else if (beat_xfer) begin
            m_axis_tid <= grant_index;
        end
    end
`endif

endmodule

// File: tb/tb_axis_frame_arbiter.sv
// tb/tb_axis_frame_arbiter.sv - self-checking bench for axis_frame_arbiter
module tb_axis_frame_arbiter;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [31:0] s_tdata  = '0;
    logic [3:0]  s_tkeep  = '1;
    logic [3:0]  s_tvalid = '0;
    logic [3:0]  s_tready;
    logic [3:0]  s_tlast  = '0;
    logic [3:0]  s_tuser  = '0;
    logic [7:0]  m_tdata;
    logic [0:0]  m_tkeep;
    logic        m_tvalid;
    logic        m_tready = 1'b0;
    logic        m_tlast;
    logic [0:0]  m_tuser;
    logic        gv;
    logic [1:0]  gi;
`ifdef AXIS_ARB_TID_EN
    logic [1:0]  m_tid;
    logic [1:0]  m3_tid;
`endif

    logic [23:0] s3_tdata  = '0;
    logic [2:0]  s3_tkeep  = '1;
    logic [2:0]  s3_tvalid = '0;
    logic [2:0]  s3_tready;
    logic [2:0]  s3_tlast  = '1;
    logic [2:0]  s3_tuser  = '0;
    logic [7:0]  m3_tdata;
    logic [0:0]  m3_tkeep;
    logic        m3_tvalid;
    logic        m3_tlast;
    logic [0:0]  m3_tuser;
    logic        gv3;
    logic [1:0]  gi3;

    always #5 clk = ~clk;

    axis_frame_arbiter #(.S_COUNT(4), .DATA_WIDTH(8)) dut (
        .clk(clk), .rst(rst),
        .s_axis_tdata(s_tdata), .s_axis_tkeep(s_tkeep), .s_axis_tvalid(s_tvalid),
        .s_axis_tready(s_tready), .s_axis_tlast(s_tlast), .s_axis_tuser(s_tuser),
        .m_axis_tdata(m_tdata), .m_axis_tkeep(m_tkeep), .m_axis_tvalid(m_tvalid),
        .m_axis_tready(m_tready), .m_axis_tlast(m_tlast), .m_axis_tuser(m_tuser),
`ifdef AXIS_ARB_TID_EN
        .m_axis_tid(m_tid),
`endif
        .grant_valid(gv), .grant_index(gi)
    );

    axis_frame_arbiter #(.S_COUNT(3), .DATA_WIDTH(8)) dut3 (
        .clk(clk), .rst(rst),
        .s_axis_tdata(s3_tdata), .s_axis_tkeep(s3_tkeep), .s_axis_tvalid(s3_tvalid),
        .s_axis_tready(s3_tready), .s_axis_tlast(s3_tlast), .s_axis_tuser(s3_tuser),
        .m_axis_tdata(m3_tdata), .m_axis_tkeep(m3_tkeep), .m_axis_tvalid(m3_tvalid),
        .m_axis_tready(1'b1), .m_axis_tlast(m3_tlast), .m_axis_tuser(m3_tuser),
`ifdef AXIS_ARB_TID_EN
        .m_axis_tid(m3_tid),
`endif
        .grant_valid(gv3), .grant_index(gi3)
    );

    typedef struct {
        logic [7:0] data;
        logic       last;
        logic       user;
        int         port;
    } beat_t;

    typedef struct {
        logic [3:0] tvalid;
        logic       mrdy;
        logic       gv;
        logic       chk_gi;
        logic [1:0] gi;
        logic [3:0] rdy;
        logic       mv;
        logic [7:0] data;
    } vec_t;

    int n_cmp = 0;
    int n_err = 0;

    // Reference model: arbitration state as plain integers, pending output beats as a queue.
    beat_t src_q[4][$];
    beat_t out_q[$];
    beat_t dut_out[$];
    int    grant_log[$];
    int    md_active = 0;
    int    md_g = 0;
    int    md_rr = 0;
    int    seq[4] = '{0, 0, 0, 0};
    logic  prev_gv = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic push_beat(input int p, input logic [7:0] d, input logic l);
        beat_t b;
        b.data = d; b.last = l; b.user = d[0] ^ d[7]; b.port = p;
        src_q[p].push_back(b);
    endtask

    task automatic push_rand_frame(input int p);
        int len;
        len = $urandom_range(1, 4);
        for (int k = 0; k < len; k++) begin
            push_beat(p, {p[1:0], seq[p][5:0]}, (k == len - 1));
            seq[p]++;
        end
    endtask

    // One clock cycle: drive sources from their queues, check the DUT against
    // the model, then advance the model at the rising edge.
    task automatic step(input logic [3:0] en, input logic mrdy);
        logic [3:0] exp_rdy;
        logic       acc;
        int         found;
        beat_t      b;
        for (int p = 0; p < 4; p++) begin
            if (src_q[p].size() > 0) begin
                s_tvalid[p]       = en[p];
                s_tdata[p*8 +: 8] = src_q[p][0].data;
                s_tlast[p]        = src_q[p][0].last;
                s_tuser[p]        = src_q[p][0].user;
            end else begin
                s_tvalid[p] = 1'b0;
            end
        end
        m_tready = mrdy;
        #1;
        exp_rdy = '0;
        if (md_active != 0 && (out_q.size() == 0 || mrdy)) exp_rdy[md_g] = 1'b1;
        chk("s_tready", s_tready, exp_rdy);
        chk("grant_valid", gv, md_active);
        if (md_active != 0) chk("grant_index", gi, md_g);
        chk("m_tvalid", m_tvalid, out_q.size() != 0);
        if (out_q.size() != 0) begin
            chk("m_tdata", m_tdata, out_q[0].data);
            chk("m_tlast", m_tlast, out_q[0].last);
            chk("m_tuser", m_tuser, out_q[0].user);
            chk("m_tkeep", m_tkeep, 1);
`ifdef AXIS_ARB_TID_EN
            chk("m_tid", m_tid, out_q[0].port);
`endif
        end
        if (m_tvalid && m_tready) begin
            b.data = m_tdata; b.last = m_tlast; b.user = m_tuser[0]; b.port = -1;
            dut_out.push_back(b);
        end
        if (gv && !prev_gv) grant_log.push_back(int'(gi));
        prev_gv = gv;
        @(posedge clk);
        acc = (md_active != 0) && s_tvalid[md_g] && (out_q.size() == 0 || mrdy);
        if (out_q.size() != 0 && mrdy) void'(out_q.pop_front());
        if (acc) begin
            b = src_q[md_g].pop_front();
            out_q.push_back(b);
            if (b.last) begin
                md_active = 0;
                md_rr = (md_g + 1) % 4;
            end
        end else if (md_active == 0 && s_tvalid != 0) begin
            found = 0;
            for (int k = 0; k < 4; k++) begin
                if (found == 0 && s_tvalid[(md_rr + k) % 4]) begin
                    md_g = (md_rr + k) % 4;
                    found = 1;
                end
            end
            md_active = 1;
        end
        @(negedge clk);
    endtask

    function automatic int busy();
        int s;
        s = out_q.size() + md_active;
        for (int p = 0; p < 4; p++) s += src_q[p].size();
        return s;
    endfunction

    task automatic drain();
        int n;
        n = 0;
        while (busy() != 0 && n < 200) begin
            step(4'hF, 1'b1);
            n++;
        end
        if (n >= 200) chk("drain_timeout", 1, 0);
        step(4'hF, 1'b1);
    endtask

    // Asserts reset between clock edges so the async path is what clears outputs.
    task automatic do_reset();
        #2;
        rst = 1'b0;
        for (int r = 0; r < 2; r++) begin
            s_tvalid = $urandom; s_tdata = $urandom; s_tlast = $urandom;
            s_tuser = $urandom; m_tready = $urandom;
            #1;
            chk("rst_s_tready", s_tready, 0);
            chk("rst_grant_valid", gv, 0);
            chk("rst_grant_index", gi, 0);
            chk("rst_m_tvalid", m_tvalid, 0);
            @(negedge clk);
            if (r == 0) #2;
        end
        for (int p = 0; p < 4; p++) src_q[p].delete();
        out_q.delete(); dut_out.delete(); grant_log.delete();
        md_active = 0; md_g = 0; md_rr = 0; prev_gv = 1'b0;
        s_tvalid = '0; m_tready = 1'b1;
        rst = 1'b1;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t tbl[12];
        int   mask;
        int   lowest;

        @(negedge clk);
        do_reset();

        // Single-beat frames, port data 0xC0|p: grant sequence 2,3 then wrap to 1, then 0.
        tbl[0]  = '{4'b0100, 1'b1, 1'b0, 1'b1, 2'd0, 4'b0000, 1'b0, 8'h00};
        tbl[1]  = '{4'b0100, 1'b1, 1'b1, 1'b1, 2'd2, 4'b0100, 1'b0, 8'h00};
        tbl[2]  = '{4'b1010, 1'b1, 1'b0, 1'b0, 2'd0, 4'b0000, 1'b1, 8'hC2};
        tbl[3]  = '{4'b1010, 1'b1, 1'b1, 1'b1, 2'd3, 4'b1000, 1'b0, 8'h00};
        tbl[4]  = '{4'b0010, 1'b1, 1'b0, 1'b0, 2'd0, 4'b0000, 1'b1, 8'hC3};
        tbl[5]  = '{4'b0010, 1'b1, 1'b1, 1'b1, 2'd1, 4'b0010, 1'b0, 8'h00};
        tbl[6]  = '{4'b0001, 1'b1, 1'b0, 1'b0, 2'd0, 4'b0000, 1'b1, 8'hC1};
        tbl[7]  = '{4'b0001, 1'b0, 1'b1, 1'b1, 2'd0, 4'b0001, 1'b0, 8'h00};
        tbl[8]  = '{4'b0000, 1'b0, 1'b0, 1'b0, 2'd0, 4'b0000, 1'b1, 8'hC0};
        tbl[9]  = '{4'b0000, 1'b0, 1'b0, 1'b0, 2'd0, 4'b0000, 1'b1, 8'hC0};
        tbl[10] = '{4'b0000, 1'b1, 1'b0, 1'b0, 2'd0, 4'b0000, 1'b1, 8'hC0};
        tbl[11] = '{4'b0000, 1'b1, 1'b0, 1'b0, 2'd0, 4'b0000, 1'b0, 8'h00};
        s_tlast = 4'hF;
        for (int p = 0; p < 4; p++) s_tdata[p*8 +: 8] = 8'hC0 | 8'(p);
        for (int i = 0; i < 12; i++) begin
            s_tvalid = tbl[i].tvalid;
            m_tready = tbl[i].mrdy;
            #1;
            chk($sformatf("tbl%0d_grant_valid", i), gv, tbl[i].gv);
            if (tbl[i].chk_gi) chk($sformatf("tbl%0d_grant_index", i), gi, tbl[i].gi);
            chk($sformatf("tbl%0d_s_tready", i), s_tready, tbl[i].rdy);
            chk($sformatf("tbl%0d_m_tvalid", i), m_tvalid, tbl[i].mv);
            if (tbl[i].mv) begin
                chk($sformatf("tbl%0d_m_tdata", i), m_tdata, tbl[i].data);
                chk($sformatf("tbl%0d_m_tlast", i), m_tlast, 1);
            end
            @(negedge clk);
        end
        s_tvalid = '0;

        // S_COUNT=3 instance: port 2 granted, then ports 0 and 1 -> wraps to 0.
        s3_tvalid = 3'b100;
        @(negedge clk); #1;
        chk("s3_grant_index_2", gi3, 2);
        chk("s3_tready_2", s3_tready, 3'b100);
        @(negedge clk);
        s3_tvalid = 3'b011;
        @(negedge clk); #1;
        chk("s3_grant_valid", gv3, 1);
        chk("s3_grant_index_0", gi3, 0);
        chk("s3_tready_0", s3_tready, 3'b001);
        @(negedge clk);
        s3_tvalid = 3'b000;
        repeat (3) @(negedge clk);

        // First grant after reset goes to the lowest requesting port.
        do_reset();
        mask = $urandom_range(1, 15);
        lowest = -1;
        for (int p = 3; p >= 0; p--) begin
            if (mask[p]) begin
                push_beat(p, 8'h50 + 8'(p), 1'b1);
                lowest = p;
            end
        end
        drain();
        chk("first_grant_after_reset", grant_log.size() > 0 ? grant_log[0] : -1, lowest);

        // Port 2 three-beat frame, then rr_ptr=3 favours port 3 over port 0.
        do_reset();
        push_beat(2, 8'hA1, 1'b0); push_beat(2, 8'hA2, 1'b0); push_beat(2, 8'hA3, 1'b1);
        drain();
        chk("p2_beats", dut_out.size(), 3);
        if (dut_out.size() == 3) begin
            chk("p2_beat0", {dut_out[0].last, dut_out[0].data}, 9'h0A1);
            chk("p2_beat1", {dut_out[1].last, dut_out[1].data}, 9'h0A2);
            chk("p2_beat2", {dut_out[2].last, dut_out[2].data}, 9'h1A3);
        end
        push_beat(0, 8'h01, 1'b1); push_beat(3, 8'h03, 1'b1);
        drain();
        chk("rr_after_p2", grant_log.size() > 1 ? grant_log[1] : -1, 3);
        chk("rr_wrap_to_0", grant_log.size() > 2 ? grant_log[2] : -1, 0);

        // All ports hold two-beat frames: grant order 0,1,2,3,0.
        do_reset();
        for (int f = 0; f < 2; f++)
            for (int p = 0; p < 4; p++) begin
                push_beat(p, {p[1:0], 6'(f * 2)}, 1'b0);
                push_beat(p, {p[1:0], 6'(f * 2 + 1)}, 1'b1);
            end
        drain();
        for (int k = 0; k < 5; k++)
            chk($sformatf("all_req_grant%0d", k), grant_log.size() > k ? grant_log[k] : -1, k % 4);

        // Backpressure: five stalled cycles mid-frame, nothing lost or duplicated.
        do_reset();
        for (int k = 0; k < 4; k++) push_beat(1, 8'hB0 + 8'(k), k == 3);
        repeat (3) step(4'hF, 1'b1);
        repeat (5) step(4'hF, 1'b0);
        drain();
        chk("bp_beats", dut_out.size(), 4);
        for (int k = 0; k < 4 && k < dut_out.size(); k++)
            chk($sformatf("bp_beat%0d", k), dut_out[k].data, 8'hB0 + 8'(k));

        // Reset mid-frame after rr_ptr moved to 3: arbitration restarts at port 0.
        do_reset();
        push_beat(2, 8'h22, 1'b1);
        for (int k = 0; k < 3; k++) push_beat(3, 8'h30 + 8'(k), k == 2);
        repeat (5) step(4'hF, 1'b1);
        do_reset();
        push_beat(3, 8'h33, 1'b1); push_beat(1, 8'h11, 1'b1);
        drain();
        chk("rst_midframe_grant", grant_log.size() > 0 ? grant_log[0] : -1, 1);

        // Randomised traffic with source tvalid gaps and output backpressure.
        do_reset();
        for (int c = 0; c < 1500; c++) begin
            for (int p = 0; p < 4; p++)
                if (src_q[p].size() < 3) push_rand_frame(p);
            step(4'($urandom), ($urandom % 4) != 0);
        end
        drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
